hazard_stall_ctrl: RTL and testbench

//  Pipeline interlock controller for the 5-stage MIPS core; works alongside the forwarding unit.

---
 rtl/hazard_stall_ctrl.sv | 100 ++++++++++
 tb/tb_hazard_stall_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock for the 5-stage core: load-use stalls, taken-branch flushes, data-memory waits.
// Control outputs are combinational (same cycle); wait state, halt flag and stall statistics are registered.
module hazard_stall_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       ID_Rs,
   input  logic [4:0]       ID_Rt,
   input  logic             ID_UseRt,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_Rt,
   input  logic             EX_BranchTaken,
   input  logic             M_MemReq,
   input  logic             M_MemAck,
   output logic             PC_Write,
   output logic             IFID_Write,
   output logic             IFID_Flush,
   output logic             IDEX_Bubble,
   output logic             EXM_Hold,
   output logic             MemTimeout,
   output logic [CNT_W-1:0] StallCount
);

   localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

   state_t          state, state_nxt;
   logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
   logic            freeze, loaduse;

   assign freeze  = M_MemReq && !M_MemAck;
   assign loaduse = EX_MemRead && (EX_Rt != 5'd0) &&
                    ((EX_Rt == ID_Rs) || (ID_UseRt && (EX_Rt == ID_Rt)));

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      PC_Write     = 1'b0;
      IFID_Write   = 1'b0;
      IFID_Flush   = 1'b0;
      IDEX_Bubble  = 1'b0;
      EXM_Hold     = 1'b0;
      if (!rst) begin
         if (state == HALT) begin
            EXM_Hold = 1'b1;
         end else begin
            // Freeze outranks branch/load-use: EX is held, so those re-evaluate after release.
            if (freeze) begin
               EXM_Hold = 1'b1;
            end else if (EX_BranchTaken) begin
               PC_Write    = 1'b1;
               IFID_Write  = 1'b1;
               IFID_Flush  = 1'b1;
               IDEX_Bubble = 1'b1;
            end else if (loaduse) begin
               IDEX_Bubble = 1'b1;
            end else begin
               PC_Write   = 1'b1;
               IFID_Write = 1'b1;
            end

            if (state == RUN) begin
               if (freeze) begin
                  state_nxt    = MEM_WAIT;
                  wait_cnt_nxt = WC_W'(1);
               end
            end else begin
               if (!freeze) begin
                  state_nxt    = RUN;
                  wait_cnt_nxt = '0;
               end else if (wait_cnt == WC_W'(MEM_TIMEOUT - 1)) begin
                  state_nxt = HALT;
               end else begin
                  wait_cnt_nxt = wait_cnt + WC_W'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RUN;
         wait_cnt   <= '0;
         MemTimeout <= 1'b0;
         StallCount <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (state_nxt == HALT)
            MemTimeout <= 1'b1;
         if (!PC_Write && (StallCount != {CNT_W{1'b1}}))
            StallCount <= StallCount + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench: instance a (MEM_TIMEOUT=4, 16-bit count), instance b (MEM_TIMEOUT=32, 4-bit count).
module tb_hazard_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] ID_Rs, ID_Rt, EX_Rt;
   logic       ID_UseRt, EX_MemRead, EX_BranchTaken, M_MemReq, M_MemAck;

   logic        pcw_a, ifw_a, iff_a, bub_a, hold_a, to_a;
   logic [15:0] cnt_a;
   logic        pcw_b, ifw_b, iff_b, bub_b, hold_b, to_b;
   logic [3:0]  cnt_b;
   logic [4:0]  ctl_a, ctl_b;

   int errors = 0;
   int checks = 0;

   localparam logic [4:0] C_IDLE = 5'b11000;
   localparam logic [4:0] C_LU   = 5'b00010;
   localparam logic [4:0] C_BR   = 5'b11110;
   localparam logic [4:0] C_FRZ  = 5'b00001;
   localparam logic [4:0] C_RST  = 5'b00000;

   assign ctl_a = {pcw_a, ifw_a, iff_a, bub_a, hold_a};
   assign ctl_b = {pcw_b, ifw_b, iff_b, bub_b, hold_b};

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRt(ID_UseRt),
      .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .EX_BranchTaken(EX_BranchTaken),
      .M_MemReq(M_MemReq), .M_MemAck(M_MemAck),
      .PC_Write(pcw_a), .IFID_Write(ifw_a), .IFID_Flush(iff_a), .IDEX_Bubble(bub_a),
      .EXM_Hold(hold_a), .MemTimeout(to_a), .StallCount(cnt_a));

   hazard_stall_ctrl #(.MEM_TIMEOUT(32), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRt(ID_UseRt),
      .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .EX_BranchTaken(EX_BranchTaken),
      .M_MemReq(M_MemReq), .M_MemAck(M_MemAck),
      .PC_Write(pcw_b), .IFID_Write(ifw_b), .IFID_Flush(iff_b), .IDEX_Bubble(bub_b),
      .EXM_Hold(hold_b), .MemTimeout(to_b), .StallCount(cnt_b));

   task automatic idle();
      ID_Rs = 5'd1; ID_Rt = 5'd2; ID_UseRt = 1'b0;
      EX_MemRead = 1'b0; EX_Rt = 5'd0; EX_BranchTaken = 1'b0;
      M_MemReq = 1'b0; M_MemAck = 1'b0;
   endtask

   // Advance one edge and land 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      checks++; if (ctl_a !== C_RST) begin errors++; $display("FAIL rst_ctl: got %b expected %b", ctl_a, C_RST); end
      checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d expected 0", cnt_a); end
      checks++; if (to_a !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b expected 0", to_a); end
      rst = 1'b0;
      #1;
      checks++; if (ctl_a !== C_IDLE) begin errors++; $display("FAIL post_rst_ctl: got %b expected %b", ctl_a, C_IDLE); end
      tick();
      checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL idle_cnt: got %0d expected 0", cnt_a); end
   endtask

   task automatic test_load_use();
      EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8;
      #1;
      checks++; if (ctl_a !== C_LU) begin errors++; $display("FAIL lu_ctl: got %b expected %b", ctl_a, C_LU); end
      tick();
      idle();
      #1;
      checks++; if (cnt_a !== 16'd1) begin errors++; $display("FAIL lu_cnt: got %0d expected 1", cnt_a); end
      checks++; if (ctl_a !== C_IDLE) begin errors++; $display("FAIL lu_release: got %b expected %b", ctl_a, C_IDLE); end
   endtask

   task automatic test_no_stall();
      EX_MemRead = 1'b1; EX_Rt = 5'd0; ID_Rs = 5'd0;
      #1;
      checks++; if (ctl_a !== C_IDLE) begin errors++; $display("FAIL r0_ctl: got %b expected %b", ctl_a, C_IDLE); end
      tick();
      EX_Rt = 5'd9; ID_Rs = 5'd3; ID_Rt = 5'd9; ID_UseRt = 1'b0;
      #1;
      checks++; if (ctl_a !== C_IDLE) begin errors++; $display("FAIL nort_ctl: got %b expected %b", ctl_a, C_IDLE); end
      tick();
      checks++; if (cnt_a !== 16'd1) begin errors++; $display("FAIL nostall_cnt: got %0d expected 1", cnt_a); end
      ID_UseRt = 1'b1;
      #1;
      checks++; if (ctl_a !== C_LU) begin errors++; $display("FAIL rt_lu_ctl: got %b expected %b", ctl_a, C_LU); end
      tick();
      idle();
      #1;
      checks++; if (cnt_a !== 16'd2) begin errors++; $display("FAIL rt_lu_cnt: got %0d expected 2", cnt_a); end
   endtask

   task automatic test_branch();
      EX_BranchTaken = 1'b1; EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8;
      #1;
      checks++; if (ctl_a !== C_BR) begin errors++; $display("FAIL br_ctl: got %b expected %b", ctl_a, C_BR); end
      tick();
      checks++; if (cnt_a !== 16'd2) begin errors++; $display("FAIL br_cnt: got %0d expected 2", cnt_a); end
      M_MemReq = 1'b1; M_MemAck = 1'b0;
      #1;
      checks++; if (ctl_a !== C_FRZ) begin errors++; $display("FAIL br_frz_ctl: got %b expected %b", ctl_a, C_FRZ); end
      tick();
      M_MemAck = 1'b1;
      #1;
      checks++; if (ctl_a !== C_BR) begin errors++; $display("FAIL br_ack_ctl: got %b expected %b", ctl_a, C_BR); end
      tick();
      idle();
      #1;
      checks++; if (cnt_a !== 16'd3) begin errors++; $display("FAIL br_frz_cnt: got %0d expected 3", cnt_a); end
   endtask

   task automatic test_mem_wait();
      M_MemReq = 1'b1; M_MemAck = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (ctl_a !== C_FRZ) begin errors++; $display("FAIL mw_ctl[%0d]: got %b expected %b", i, ctl_a, C_FRZ); end
         tick();
      end
      M_MemAck = 1'b1;
      #1;
      checks++; if (ctl_a !== C_IDLE) begin errors++; $display("FAIL mw_ack_ctl: got %b expected %b", ctl_a, C_IDLE); end
      tick();
      idle();
      #1;
      checks++; if (cnt_a !== 16'd6) begin errors++; $display("FAIL mw_cnt: got %0d expected 6", cnt_a); end
      checks++; if (to_a !== 1'b0) begin errors++; $display("FAIL mw_timeout: got %b expected 0", to_a); end
      checks++; if (ctl_a !== C_IDLE) begin errors++; $display("FAIL mw_run_ctl: got %b expected %b", ctl_a, C_IDLE); end
   endtask

   task automatic test_timeout();
      M_MemReq = 1'b1; M_MemAck = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (to_a !== 1'b0) begin errors++; $display("FAIL to_early[%0d]: got %b expected 0", i, to_a); end
         tick();
      end
      checks++; if (to_a !== 1'b1) begin errors++; $display("FAIL to_set: got %b expected 1", to_a); end
      checks++; if (cnt_a !== 16'd10) begin errors++; $display("FAIL to_cnt: got %0d expected 10", cnt_a); end
      M_MemAck = 1'b1;
      #1;
      checks++; if (ctl_a !== C_FRZ) begin errors++; $display("FAIL halt_ack_ctl: got %b expected %b", ctl_a, C_FRZ); end
      tick();
      idle();
      tick();
      checks++; if (ctl_a !== C_FRZ) begin errors++; $display("FAIL halt_idle_ctl: got %b expected %b", ctl_a, C_FRZ); end
      checks++; if (to_a !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", to_a); end
      checks++; if (cnt_a !== 16'd12) begin errors++; $display("FAIL halt_cnt: got %0d expected 12", cnt_a); end
      rst = 1'b1;
      #1;
      checks++; if (to_a !== 1'b0) begin errors++; $display("FAIL to_rst: got %b expected 0", to_a); end
      checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL to_rst_cnt: got %0d expected 0", cnt_a); end
      checks++; if (ctl_a !== C_RST) begin errors++; $display("FAIL to_rst_ctl: got %b expected %b", ctl_a, C_RST); end
      tick();
      rst = 1'b0;
      #1;
      checks++; if (ctl_a !== C_IDLE) begin errors++; $display("FAIL to_run_ctl: got %b expected %b", ctl_a, C_IDLE); end
      tick();
   endtask

   task automatic test_saturation();
      M_MemReq = 1'b1; M_MemAck = 1'b0;
      for (int i = 0; i < 14; i++) tick();
      checks++; if (cnt_b !== 4'd14) begin errors++; $display("FAIL sat_14: got %0d expected 14", cnt_b); end
      for (int i = 0; i < 6; i++) tick();
      checks++; if (cnt_b !== 4'd15) begin errors++; $display("FAIL sat_cap: got %0d expected 15", cnt_b); end
      checks++; if (ctl_b !== C_FRZ) begin errors++; $display("FAIL sat_ctl: got %b expected %b", ctl_b, C_FRZ); end
      checks++; if (to_b !== 1'b0) begin errors++; $display("FAIL sat_timeout: got %b expected 0", to_b); end
      rst = 1'b1;
      #1;
      checks++; if (cnt_b !== 4'd0) begin errors++; $display("FAIL sat_rst_cnt: got %0d expected 0", cnt_b); end
      tick();
      rst = 1'b0;
      idle();
      #1;
      checks++; if (ctl_b !== C_IDLE) begin errors++; $display("FAIL sat_run_ctl: got %b expected %b", ctl_b, C_IDLE); end
      tick();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_stall();
      test_branch();
      test_mem_wait();
      test_timeout();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
